// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Memory-mapped interrupt controller between peripheral interrupt sources
// and the CPU IRQ input. Rising edges on src are captured into PEND, then
// filtered by MASK and the global enable. The lowest-index active source wins.
// irq is raised only while the CPU is in user mode (kernel=0). The request /
// kernel entry / service / return sequence is tracked from the kernel-mode
// bit (PC[31]).
//
// Register map (word aligned, addr[1:0] ignored):
//   BASE+0x0 PEND  : read-only, write-1-to-clear
//   BASE+0x4 MASK  : read/write, bits [NSRC-1:0], 1 = enabled
//   BASE+0x8 CTRL  : read/write, bit0 = EN
//   BASE+0xC CAUSE : read-only, bit31 = valid, bits [2:0] = source index
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   rd, wr  in   bus strobes, already qualified by addr[30]
//   addr    in   32-bit byte address
//   wdata   in   32-bit write data
//   rdata   out  32-bit read data, combinational, 0 unless rd hits a register
//   src     in   NSRC level interrupt requests
//   kernel  in   CPU kernel-mode flag (PC[31])
//   irq     out  registered interrupt request to the CPU
//   busy    out  high while a request is pending entry or being serviced
//
// Optional build macro IRQC_SYNC_EN: src passes through a two-flop
// synchronizer before edge detection. This adds 2 clk to the edge-to-PEND
// latency.
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int unsigned NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src,
    input  logic            kernel,
    output logic            irq,
    output logic            busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    localparam logic [29:0] BASE_W = BASE[31:2];

    // Address decode on word address
    logic [29:0] word_addr;
    logic        sel_pend, sel_mask, sel_ctrl, sel_cause;

    assign word_addr = addr[31:2];
    assign sel_pend  = (word_addr == BASE_W);
    assign sel_mask  = (word_addr == BASE_W + 30'd1);
    assign sel_ctrl  = (word_addr == BASE_W + 30'd2);
    assign sel_cause = (word_addr == BASE_W + 30'd3);

    // Byte-lane bits and unused write-data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    // Source path feeding the edge detector
    logic [NSRC-1:0] src_s;
`ifdef IRQC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    // State
    logic [NSRC-1:0] src_prev_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            en_q, en_d;
    logic            cause_valid_q, cause_valid_d;
    logic [2:0]      cause_idx_q, cause_idx_d;
    state_t          state_q, state_d;
    logic            irq_q, irq_d;
    logic            kernel_q;

    logic [NSRC-1:0] rise, clr, act;
    logic [2:0]      winner;
    logic            kernel_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev_q    <= '0;
            pend_q        <= '0;
            mask_q        <= '0;
            en_q          <= 1'b0;
            cause_valid_q <= 1'b0;
            cause_idx_q   <= '0;
            state_q       <= ST_IDLE;
            irq_q         <= 1'b0;
            kernel_q      <= 1'b0;
        end else begin
            src_prev_q    <= src_s;
            pend_q        <= pend_d;
            mask_q        <= mask_d;
            en_q          <= en_d;
            cause_valid_q <= cause_valid_d;
            cause_idx_q   <= cause_idx_d;
            state_q       <= state_d;
            irq_q         <= irq_d;
            kernel_q      <= kernel;
        end
    end

    // Register file next-state. A new edge beats a simultaneous W1C.
    assign rise   = src_s & ~src_prev_q;
    assign clr    = (wr && sel_pend) ? wdata[NSRC-1:0] : '0;
    assign pend_d = (pend_q & ~clr) | rise;
    assign mask_d = (wr && sel_mask) ? wdata[NSRC-1:0] : mask_q;
    assign en_d   = (wr && sel_ctrl) ? wdata[0] : en_q;

    assign act         = pend_q & mask_q & {NSRC{en_q}};
    assign kernel_fall = kernel_q & ~kernel;

    // Priority encoder. Descending scan leaves the lowest active index.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) winner = 3'(i);
        end
    end

    // NOTE: every signal driven here gets a default first. This prevents
    // latch inference on paths that do not assign it.
    always_comb begin
        state_d       = state_q;
        irq_d         = 1'b0;
        cause_valid_d = cause_valid_q;
        cause_idx_d   = cause_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                // Requests wait while the CPU is already in kernel mode
                if (act != '0 && !kernel) begin
                    cause_valid_d = 1'b1;
                    cause_idx_d   = winner;
                    irq_d         = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (kernel) begin
                    state_d = ST_SERVICE;
                end else if (act == '0) begin
                    // Software removed the source before the CPU took it
                    cause_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (kernel_fall) begin
                    cause_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign irq  = irq_q;
    assign busy = (state_q == ST_REQ) || (state_q == ST_SERVICE);

    // Read mux
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_pend)       rdata = 32'(pend_q);
            else if (sel_mask)  rdata = 32'(mask_q);
            else if (sel_ctrl)  rdata = {31'd0, en_q};
            else if (sel_cause) rdata = {cause_valid_q, 28'd0, cause_idx_q};
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int unsigned NSRC    = 4;
    localparam logic [31:0] BASE    = 32'h40000030;
    localparam logic [31:0] A_PEND  = BASE;
    localparam logic [31:0] A_MASK  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL  = BASE + 32'h8;
    localparam logic [31:0] A_CAUSE = BASE + 32'hC;

    logic            clk;
    logic            reset;
    logic            rd;
    logic            wr;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [NSRC-1:0] src;
    logic            kernel;
    logic            irq;
    logic            busy;

    irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .src    (src),
        .kernel (kernel),
        .irq    (irq),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cmp(input logic [31:0] a);
        rd   = 1'b1;
        addr = a;
        #1;
        pop_cmp(rdata);
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        src = '0; kernel = 1'b0;
        tick();
        tick();

        // Reset state
        push("rst_pend", 32'h0);  read_cmp(A_PEND);
        push("rst_mask", 32'h0);  read_cmp(A_MASK);
        push("rst_ctrl", 32'h0);  read_cmp(A_CTRL);
        push("rst_cause", 32'h0); read_cmp(A_CAUSE);
        push("rst_irq", 32'h0);   pop_cmp(32'(irq));
        push("rst_busy", 32'h0);  pop_cmp(32'(busy));
        reset = 1'b1;
        tick();

        // Configure, then a single src[2] pulse
        wr_reg(A_MASK, 32'hF);
        wr_reg(A_CTRL, 32'h1);
        push("mask_rb", 32'hF);     read_cmp(A_MASK);
        push("ctrl_rb", 32'h1);     read_cmp(A_CTRL);
        push("unmapped_hi", 32'h0); read_cmp(BASE + 32'h10);
        push("unmapped_lo", 32'h0); read_cmp(BASE - 32'h4);
        addr = A_MASK; #1;
        push("rd_low_zero", 32'h0); pop_cmp(rdata);
        addr = '0;

        src = 4'b0100;
        push("pend_1clk", 32'h4);
        push("irq_at_1clk", 32'h0);
        push("irq_at_2clk", 32'h1);
        push("busy_req", 32'h1);
        push("cause_src2", 32'h80000002);
        tick();
        src = '0;
        read_cmp(A_PEND);
        pop_cmp(32'(irq));
        tick();
        pop_cmp(32'(irq));
        pop_cmp(32'(busy));
        read_cmp(A_CAUSE);

        // Kernel entry
        kernel = 1'b1;
        push("irq_kentry", 32'h0);
        push("cause_service", 32'h80000002);
        push("busy_service", 32'h1);
        tick();
        pop_cmp(32'(irq));
        read_cmp(A_CAUSE);
        pop_cmp(32'(busy));

        // Return: clear, drop kernel
        wr_reg(A_PEND, 32'h4);
        kernel = 1'b0;
        tick();
        push("busy_ret", 32'h0);        pop_cmp(32'(busy));
        push("irq_ret", 32'h0);         pop_cmp(32'(irq));
        push("cause_ret_inval", 32'h2); read_cmp(A_CAUSE);

        // src[3] and src[1] together: priority picks index 1
        src = 4'b1010;
        tick();
        src = '0;
        push("pend_two", 32'hA); read_cmp(A_PEND);
        tick();
        push("irq_two", 32'h1);          pop_cmp(32'(irq));
        push("cause_idx1", 32'h80000001); read_cmp(A_CAUSE);
        kernel = 1'b1;
        tick();
        push("irq_kentry2", 32'h0); pop_cmp(32'(irq));
        wr_reg(A_PEND, 32'h2);
        kernel = 1'b0;
        tick();
        push("irq_idle_gap", 32'h0);  pop_cmp(32'(irq));
        push("busy_idle_gap", 32'h0); pop_cmp(32'(busy));
        tick();
        push("irq_b2b", 32'h1);           pop_cmp(32'(irq));
        push("cause_idx3", 32'h80000003); read_cmp(A_CAUSE);
        kernel = 1'b1;
        tick();
        wr_reg(A_PEND, 32'h8);
        kernel = 1'b0;
        tick();
        push("pend_clear_all", 32'h0); read_cmp(A_PEND);

        // Edge while in kernel mode is deferred
        kernel = 1'b1;
        src = 4'b0001;
        tick();
        src = '0;
        push("pend_in_kernel", 32'h1); read_cmp(A_PEND);
        tick();
        push("irq_deferred_a", 32'h0); pop_cmp(32'(irq));
        tick();
        push("irq_deferred_b", 32'h0);  pop_cmp(32'(irq));
        push("busy_deferred", 32'h0);   pop_cmp(32'(busy));
        kernel = 1'b0;
        tick();
        push("irq_after_kdrop", 32'h1);  pop_cmp(32'(irq));
        push("cause_idx0", 32'h80000000); read_cmp(A_CAUSE);
        kernel = 1'b1;
        tick();
        wr_reg(A_PEND, 32'h1);
        kernel = 1'b0;
        tick();

        // Cancel in REQ by W1C before kernel entry
        src = 4'b0010;
        tick();
        src = '0;
        tick();
        push("irq_req_src1", 32'h1); pop_cmp(32'(irq));
        wr_reg(A_PEND, 32'h2);
        tick();
        push("irq_cancel", 32'h0);        pop_cmp(32'(irq));
        push("busy_cancel", 32'h0);       pop_cmp(32'(busy));
        push("cause_cancel_inval", 32'h1); read_cmp(A_CAUSE);
        tick();
        push("irq_no_rereq", 32'h0); pop_cmp(32'(irq));

        // Edge and W1C in the same cycle: set wins. src[0] is then held high.
        wr = 1'b1; addr = A_PEND; wdata = 32'h1; src = 4'b0001;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
        push("pend_set_wins", 32'h1); read_cmp(A_PEND);
        tick();
        push("irq_req_final", 32'h1);  pop_cmp(32'(irq));
        push("busy_req_final", 32'h1); pop_cmp(32'(busy));

        // Asynchronous reset in the middle of REQ
        reset = 1'b0;
        #1;
        push("rst2_irq", 32'h0);   pop_cmp(32'(irq));
        push("rst2_busy", 32'h0);  pop_cmp(32'(busy));
        push("rst2_pend", 32'h0);  read_cmp(A_PEND);
        push("rst2_mask", 32'h0);  read_cmp(A_MASK);
        push("rst2_ctrl", 32'h0);  read_cmp(A_CTRL);
        push("rst2_cause", 32'h0); read_cmp(A_CAUSE);
        tick();
        reset = 1'b1;

        // A held-high src pends once after reset, and does not re-pend after a clear
        tick();
        push("held_pend_once", 32'h1); read_cmp(A_PEND);
        push("held_irq_masked", 32'h0); pop_cmp(32'(irq));
        wr_reg(A_PEND, 32'h1);
        tick();
        push("held_no_repend", 32'h0); read_cmp(A_PEND);
        src = '0;

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
